// File: rtl/egg_timer_core.sv
// egg_timer_core: kitchen-timer controller with its countdown datapath.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   tick       - one-cycle enable pulse (nominally 1 Hz)
//   set        - pulse: enter set mode / advance between seconds and minutes field
//   inc, dec   - pulses: step the selected field up or down (saturating)
//   run        - pulse: start / pause / resume / acknowledge the alarm
//   clear      - pulse: abort to INIT and zero the count (preset is kept)
//   count      - remaining or edited time in binary seconds
//   state_oh   - one-hot state {READY,DONE,PAUSED,RUNNING,SET_MIN,SET_SEC,INIT}
//   flash      - alarm flash, toggles on each tick while DONE, 0 elsewhere
//   done_pulse - single-cycle pulse on entry to DONE
module egg_timer_core #(
    parameter int CNT_W       = 13,
    parameter int MAX_COUNT   = 5999,
    parameter int STEP_FINE   = 1,
    parameter int STEP_COARSE = 60,
    parameter int FLASH_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             set,
    input  logic             inc,
    input  logic             dec,
    input  logic             run,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [6:0]       state_oh,
    output logic             flash,
    output logic             done_pulse
);

    // One-hot encoding so the state register itself is the state_oh output.
    typedef enum logic [6:0] {
        INIT    = 7'b0000001,
        SET_SEC = 7'b0000010,
        SET_MIN = 7'b0000100,
        RUNNING = 7'b0001000,
        PAUSED  = 7'b0010000,
        DONE    = 7'b0100000,
        READY   = 7'b1000000
    } state_t;

    localparam int FC_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS + 1) : 1;
    localparam logic [FC_W-1:0]  FLASH_LAST = FC_W'(FLASH_TICKS - 1);
    localparam logic [CNT_W:0]   MAX_EXT    = (CNT_W + 1)'(MAX_COUNT);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_COUNT);

    state_t           state;
    logic [CNT_W-1:0] preset;
    logic [FC_W-1:0]  flashCnt;

    logic [CNT_W:0]   stepExt;
    logic [CNT_W:0]   sumExt;
    logic [CNT_W:0]   diffExt;
    logic [CNT_W-1:0] incVal;
    logic [CNT_W-1:0] decVal;

    assign state_oh = state;

    // Field step arithmetic in CNT_W+1 bits so overflow and borrow are visible
    // before clamping to [0, MAX_COUNT].
    always_comb begin
        stepExt = (state == SET_MIN) ? (CNT_W + 1)'(STEP_COARSE)
                                     : (CNT_W + 1)'(STEP_FINE);
        sumExt  = {1'b0, count} + stepExt;
        diffExt = {1'b0, count} - stepExt;
        incVal  = (sumExt > MAX_EXT) ? MAX_CNT : sumExt[CNT_W-1:0];
        decVal  = diffExt[CNT_W] ? '0 : diffExt[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        done_pulse <= 1'b0;
        if (reset) begin
            state    <= INIT;
            count    <= '0;
            preset   <= '0;
            flash    <= 1'b0;
            flashCnt <= '0;
        end else if (clear) begin
            state    <= INIT;
            count    <= '0;
            flash    <= 1'b0;
            flashCnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (set) state <= SET_SEC;
                end
                SET_SEC, SET_MIN: begin
                    // run is consumed even when the count is zero (start refused).
                    if (run) begin
                        if (count != '0) begin
                            state  <= RUNNING;
                            preset <= count;
                        end
                    end else if (set) begin
                        state <= (state == SET_SEC) ? SET_MIN : SET_SEC;
                    end else if (inc && !dec) begin
                        count <= incVal;
                    end else if (dec && !inc) begin
                        count <= decVal;
                    end
                end
                READY, PAUSED: begin
                    if (run)      state <= RUNNING;
                    else if (set) state <= SET_SEC;
                end
                RUNNING: begin
                    if (run) begin
                        state <= PAUSED;
                    end else if (tick) begin
                        if (count <= CNT_W'(1)) begin
                            count      <= '0;
                            state      <= DONE;
                            flash      <= 1'b1;
                            flashCnt   <= '0;
                            done_pulse <= 1'b1;
                        end else begin
                            count <= count - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (run) begin
                        state <= READY;
                        count <= preset;
                        flash <= 1'b0;
                    end else if (set) begin
                        state <= SET_SEC;
                        count <= preset;
                        flash <= 1'b0;
                    end else if (tick) begin
                        if ((FLASH_TICKS != 0) && (flashCnt == FLASH_LAST)) begin
                            state    <= READY;
                            count    <= preset;
                            flash    <= 1'b0;
                            flashCnt <= '0;
                        end else begin
                            flash    <= ~flash;
                            flashCnt <= flashCnt + FC_W'(1);
                        end
                    end
                end
                default: begin
                    state <= INIT;
                    count <= '0;
                    flash <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_egg_timer_core.sv
module tb_egg_timer_core;

    localparam int CW   = 13;
    localparam int MAXC = 5999;
    localparam int SF   = 1;
    localparam int SC   = 60;

    localparam logic [6:0] E_NONE = 7'h00;
    localparam logic [6:0] E_TICK = 7'h01;
    localparam logic [6:0] E_DEC  = 7'h02;
    localparam logic [6:0] E_INC  = 7'h04;
    localparam logic [6:0] E_SET  = 7'h08;
    localparam logic [6:0] E_RUN  = 7'h10;
    localparam logic [6:0] E_CLR  = 7'h20;
    localparam logic [6:0] E_RST  = 7'h40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, tick = 1'b0, set = 1'b0, inc = 1'b0;
    logic dec = 1'b0, run = 1'b0, clear = 1'b0;

    logic [CW-1:0] countA, countB;
    logic [6:0]    sohA, sohB;
    logic          flashA, flashB, dpA, dpB;

    egg_timer_core #(.CNT_W(CW), .MAX_COUNT(MAXC), .STEP_FINE(SF),
                     .STEP_COARSE(SC), .FLASH_TICKS(10)) dutA (
        .clk(clk), .reset(reset), .tick(tick), .set(set), .inc(inc),
        .dec(dec), .run(run), .clear(clear), .count(countA),
        .state_oh(sohA), .flash(flashA), .done_pulse(dpA));

    egg_timer_core #(.CNT_W(CW), .MAX_COUNT(MAXC), .STEP_FINE(SF),
                     .STEP_COARSE(SC), .FLASH_TICKS(0)) dutB (
        .clk(clk), .reset(reset), .tick(tick), .set(set), .inc(inc),
        .dec(dec), .run(run), .clear(clear), .count(countB),
        .state_oh(sohB), .flash(flashB), .done_pulse(dpB));

    // Reference model: named modes, plain integer time arithmetic.
    typedef enum int {M_INIT, M_SSEC, M_SMIN, M_RUN, M_PAUSE, M_DONE, M_READY} mode_t;

    typedef struct {
        int cnt;
        int soh;
        int fl;
        int dp;
    } exp_t;

    exp_t  qA[$];
    exp_t  qB[$];
    mode_t mMode[2];
    int    mCnt[2], mPre[2], mFl[2], mFc[2], mDp[2];
    int    flashTicks[2] = '{10, 0};

    int total = 0;
    int bad   = 0;

    function automatic int modeOneHot(mode_t m);
        case (m)
            M_INIT:  return 1;
            M_SSEC:  return 2;
            M_SMIN:  return 4;
            M_RUN:   return 8;
            M_PAUSE: return 16;
            M_DONE:  return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void modelStep(int k, logic [6:0] ev);
        bit eRst, eClr, eRun, eSet, eInc, eDec, eTick;
        int stepSz;
        {eRst, eClr, eRun, eSet, eInc, eDec, eTick} = ev;
        mDp[k] = 0;
        if (eRst) begin
            mMode[k] = M_INIT; mCnt[k] = 0; mPre[k] = 0; mFl[k] = 0; mFc[k] = 0;
        end else if (eClr) begin
            mMode[k] = M_INIT; mCnt[k] = 0; mFl[k] = 0; mFc[k] = 0;
        end else begin
            case (mMode[k])
                M_INIT: if (eSet) mMode[k] = M_SSEC;
                M_SSEC, M_SMIN: begin
                    stepSz = (mMode[k] == M_SMIN) ? SC : SF;
                    if (eRun) begin
                        if (mCnt[k] != 0) begin
                            mMode[k] = M_RUN;
                            mPre[k]  = mCnt[k];
                        end
                    end else if (eSet) begin
                        mMode[k] = (mMode[k] == M_SSEC) ? M_SMIN : M_SSEC;
                    end else if (eInc && !eDec) begin
                        mCnt[k] = imin(mCnt[k] + stepSz, MAXC);
                    end else if (eDec && !eInc) begin
                        mCnt[k] = imax(mCnt[k] - stepSz, 0);
                    end
                end
                M_READY, M_PAUSE: begin
                    if (eRun)      mMode[k] = M_RUN;
                    else if (eSet) mMode[k] = M_SSEC;
                end
                M_RUN: begin
                    if (eRun) begin
                        mMode[k] = M_PAUSE;
                    end else if (eTick) begin
                        mCnt[k] = mCnt[k] - 1;
                        if (mCnt[k] == 0) begin
                            mMode[k] = M_DONE; mFl[k] = 1; mFc[k] = 0; mDp[k] = 1;
                        end
                    end
                end
                M_DONE: begin
                    if (eRun) begin
                        mMode[k] = M_READY; mCnt[k] = mPre[k]; mFl[k] = 0;
                    end else if (eSet) begin
                        mMode[k] = M_SSEC; mCnt[k] = mPre[k]; mFl[k] = 0;
                    end else if (eTick) begin
                        mFc[k] = mFc[k] + 1;
                        if (flashTicks[k] > 0 && mFc[k] == flashTicks[k]) begin
                            mMode[k] = M_READY; mCnt[k] = mPre[k]; mFl[k] = 0;
                        end else begin
                            mFl[k] = 1 - mFl[k];
                        end
                    end
                end
                default: mMode[k] = M_INIT;
            endcase
        end
    endfunction

    function automatic exp_t snapshot(int k);
        exp_t e;
        e.cnt = mCnt[k];
        e.soh = modeOneHot(mMode[k]);
        e.fl  = mFl[k];
        e.dp  = mDp[k];
        return e;
    endfunction

    // Stimulus: drive on the falling edge, predict, queue the expectation.
    task automatic drive(input logic [6:0] ev);
        @(negedge clk);
        {reset, clear, run, set, inc, dec, tick} = ev;
        for (int k = 0; k < 2; k++) modelStep(k, ev);
        qA.push_back(snapshot(0));
        qB.push_back(snapshot(1));
    endtask

    task automatic driveN(input logic [6:0] ev, input int n);
        for (int i = 0; i < n; i++) drive(ev);
    endtask

    task automatic randPhase(input int n, input int pRst, input int pClr, input int pRun,
                             input int pSet, input int pInc, input int pDec, input int pTick);
        logic [6:0] ev;
        for (int i = 0; i < n; i++) begin
            ev = E_NONE;
            if ($urandom_range(0, 999) < pRst)  ev = ev | E_RST;
            if ($urandom_range(0, 999) < pClr)  ev = ev | E_CLR;
            if ($urandom_range(0, 999) < pRun)  ev = ev | E_RUN;
            if ($urandom_range(0, 999) < pSet)  ev = ev | E_SET;
            if ($urandom_range(0, 999) < pInc)  ev = ev | E_INC;
            if ($urandom_range(0, 999) < pDec)  ev = ev | E_DEC;
            if ($urandom_range(0, 999) < pTick) ev = ev | E_TICK;
            drive(ev);
        end
    endtask

    task automatic cmp(input string name, input int k, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %0d want %0d", name, k, $time, got, want);
        end
    endtask

    // Monitor: sample one time unit after each rising edge and check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qA.size() > 0) begin
                e = qA.pop_front();
                cmp("count", 0, int'(countA), e.cnt);
                cmp("state_oh", 0, int'(sohA), e.soh);
                cmp("flash", 0, int'(flashA), e.fl);
                cmp("done_pulse", 0, int'(dpA), e.dp);
            end
            if (qB.size() > 0) begin
                e = qB.pop_front();
                cmp("count", 1, int'(countB), e.cnt);
                cmp("state_oh", 1, int'(sohB), e.soh);
                cmp("flash", 1, int'(flashB), e.fl);
                cmp("done_pulse", 1, int'(dpB), e.dp);
            end
        end
    end

    initial begin
        int waitCyc;

        // Program 2:03 and start.
        drive(E_RST);
        drive(E_SET);
        driveN(E_INC, 3);
        drive(E_SET);
        driveN(E_INC, 2);
        drive(E_RUN);

        // Count down to DONE, then flash phase (auto re-arm vs. hold).
        driveN(E_TICK, 123);
        drive(E_NONE);
        driveN(E_TICK, 10);
        driveN(E_TICK, 40);
        drive(E_RUN);
        drive(E_CLR);

        // Pause with a coincident tick, frozen while paused, resume.
        drive(E_SET);
        driveN(E_INC, 30);
        drive(E_RUN);
        drive(E_RUN | E_TICK);
        driveN(E_TICK, 5);
        drive(E_RUN);
        drive(E_TICK);

        // Clear mid-run.
        drive(E_CLR);
        drive(E_SET);
        driveN(E_INC, 17);
        drive(E_SET);
        drive(E_INC);
        drive(E_RUN);
        driveN(E_TICK, 3);
        drive(E_CLR);

        // Saturation at both ends, inc&dec together, start refused at zero.
        drive(E_SET);
        drive(E_DEC);
        driveN(E_INC, 50);
        drive(E_SET);
        driveN(E_INC, 99);
        drive(E_INC);
        drive(E_INC | E_DEC);
        drive(E_DEC);
        drive(E_SET);
        drive(E_INC | E_DEC);
        drive(E_CLR);
        drive(E_SET);
        drive(E_RUN);
        drive(E_SET | E_INC);

        // Reset while flashing, with run and tick asserted.
        drive(E_CLR);
        drive(E_SET);
        driveN(E_INC, 2);
        drive(E_RUN);
        driveN(E_TICK, 2);
        drive(E_TICK);
        drive(E_RST | E_RUN | E_TICK);
        drive(E_NONE);

        // Randomised traffic: busy mix, then long countdowns.
        randPhase(3000, 2, 5, 30, 30, 120, 80, 300);
        randPhase(3000, 0, 1, 6, 6, 60, 10, 500);
        drive(E_NONE);

        waitCyc = 0;
        while ((qA.size() > 0 || qB.size() > 0) && waitCyc < 20) begin
            @(posedge clk);
            waitCyc++;
        end
        #2;
        total++;
        if (qA.size() > 0 || qB.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", qA.size() + qB.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
